detect_event_logger: RTL

Downstream consumer of the 10110 sequence detector. Each asserted detection strobe is stamped with a free-running cycle timestamp and pushed into a small show-ahead FIFO. The block also keeps a saturating detection count and a sticky overflow flag. Software or a test harness drains the timestamps through a single-cycle read handshake.

---
 rtl/detect_event_logger_if.sv | 29 ++
 rtl/detect_event_logger.sv | 97 +++++++++
 2 files changed

// File: rtl/detect_event_logger_if.sv
// Bus between the event logger and its consumer: detection strobe, clear,
// FIFO read handshake and status outputs.
interface detect_event_logger_if #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic            det_in;
    logic            rd_en;
    logic            clr;
    logic            rd_valid;
    logic [TS_W-1:0] rd_data;
    logic [LW-1:0]   fifo_level;
    logic            full;
    logic [CNT_W-1:0] ev_count;
    logic            overflow;

    modport master (
        output det_in, rd_en, clr,
        input  rd_valid, rd_data, fifo_level, full, ev_count, overflow
    );

    modport slave (
        input  det_in, rd_en, clr,
        output rd_valid, rd_data, fifo_level, full, ev_count, overflow
    );
endinterface

// File: rtl/detect_event_logger.sv
// Timestamps each detection strobe into a show-ahead FIFO and keeps a
// saturating detection count plus a sticky drop flag.
module detect_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input logic                  clk,
    input logic                  reset,
    detect_event_logger_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic is_empty;
    logic is_full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        is_empty = (level == '0);
        is_full  = (level == LW'(DEPTH));
        // A pop frees the slot for a same-cycle push even when full.
        pop      = bus.rd_en && !is_empty;
        push     = bus.det_in && (!is_full || pop);
        drop     = bus.det_in && is_full && !pop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    // Storage is not reset; rd_data is gated by occupancy instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ts;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            if (bus.clr) begin
                cnt <= bus.det_in ? CNT_W'(1) : '0;
            end else if (bus.det_in && (cnt != '1)) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (bus.clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign bus.rd_valid   = !is_empty;
    assign bus.rd_data    = is_empty ? '0 : mem[rd_ptr];
    assign bus.fifo_level = level;
    assign bus.full       = is_full;
    assign bus.ev_count   = cnt;
    assign bus.overflow   = ovf;
endmodule
